level_writer: RTL and testbench

Write-side controller for the 15×20 tile map of 3-bit tile codes that the display and collision logic read by pixel coordinate. It produces a single registered write port into the tile storage, and it is the only block allowed to modify the map. It supports three operations:
- clearing the whole map to one tile code;
- loading a full level as a row-major tile stream;
- overwriting a single tile addressed by pixel coordinate, used by gameplay events such as breaking a block or collecting an item.

---
 rtl/level_writer.sv | 251 +++++++++++++++++++++++++
 tb/tb_level_writer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/level_writer.sv
// -----------------------------------------------------------------------------
// level_writer
//
// Write-side controller for the 15x20 tile map (3-bit tile codes). It owns the
// single registered write port into tile storage and performs three jobs:
//   * CLEAR : fill every tile with one code, one write per cycle, row-major.
//   * LOAD  : accept a row-major tile stream (valid/ready) and write it out.
//   * point write : overwrite one tile addressed by pixel coordinate.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   clear_start, fill_tile     one-cycle clear request and its tile code
//   load_start                 one-cycle level-load request
//   tile_valid/tile_data       level stream in; tile_ready is the accept
//   wr_req, wr_x, wr_y, wr_tile  level-held point-write request
//   wr_ack / wr_err            one-cycle outcome pulses of a point write
//   mem_we/mem_row/mem_col/mem_data  registered tile-storage write port
//   busy                       CLEAR or LOAD in progress
//   done                       one-cycle pulse when a clear or load completes
// -----------------------------------------------------------------------------
module level_writer #(
  parameter int ROW_MAX = 14,
  parameter int COL_MAX = 19,
  parameter int LEFT    = 144,
  parameter int TOP     = 35
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_start,
  input  logic [2:0] fill_tile,
  input  logic       load_start,
  input  logic       tile_valid,
  input  logic [2:0] tile_data,
  output logic       tile_ready,
  input  logic       wr_req,
  input  logic [9:0] wr_x,
  input  logic [9:0] wr_y,
  input  logic [2:0] wr_tile,
  output logic       wr_ack,
  output logic       wr_err,
  output logic       mem_we,
  output logic [4:0] mem_row,
  output logic [4:0] mem_col,
  output logic [2:0] mem_data,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, CLEAR, LOAD} state_t;

  localparam logic [4:0] ROW_LAST = 5'(ROW_MAX);
  localparam logic [4:0] COL_LAST = 5'(COL_MAX);
  localparam logic [9:0] LEFT_C   = 10'(LEFT);
  localparam logic [9:0] TOP_C    = 10'(TOP);

  state_t     state, state_next;

  // (cnt_row, cnt_col) is the position of the next bulk write.
  logic [4:0] cnt_row, cnt_col, cnt_row_next, cnt_col_next;
  logic [4:0] adv_row, adv_col;
  logic       cnt_at_end;

  logic [2:0] fill_q, fill_next;

  // Set when the final bulk write has been issued; the following cycle emits
  // done and returns to IDLE, so done always trails the last write by one.
  logic       last_wr, last_next;

  logic       tile_ready_next, wr_ack_next, wr_err_next, mem_we_next;
  logic       busy_next, done_next;
  logic [4:0] mem_row_next, mem_col_next;
  logic [2:0] mem_data_next;

  logic [4:0] pw_row, pw_col;
  logic       pw_ok;
  logic       accept;

  // Off-map coordinates left of / above the map wrap to a large 10-bit value,
  // which lands at index >= 27, so one upper-bound check covers both sides.
  assign pw_row = 5'((wr_y - TOP_C) >> 5);
  assign pw_col = 5'((wr_x - LEFT_C) >> 5);
  assign pw_ok  = (pw_row <= ROW_LAST) && (pw_col <= COL_LAST);

  assign accept     = tile_valid & tile_ready;
  assign cnt_at_end = (cnt_row == ROW_LAST) && (cnt_col == COL_LAST);

  // Row-major advance of the bulk-write counter.
  always_comb begin
    // NOTE: every variable gets a value on every path of a combinational
    // block; a missed branch would otherwise infer a latch.
    adv_row = cnt_row;
    adv_col = cnt_col + 5'd1;
    if (cnt_col == COL_LAST) begin
      adv_col = 5'd0;
      adv_row = (cnt_row == ROW_LAST) ? 5'd0 : cnt_row + 5'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (clear_start)     state_next = CLEAR;
        else if (load_start) state_next = LOAD;
      end
      CLEAR, LOAD: begin
        if (last_wr) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath next values (registered below)
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_row_next    = cnt_row;
    cnt_col_next    = cnt_col;
    fill_next       = fill_q;
    last_next       = 1'b0;
    tile_ready_next = 1'b0;
    wr_ack_next     = 1'b0;
    wr_err_next     = 1'b0;
    mem_we_next     = 1'b0;
    mem_row_next    = mem_row;
    mem_col_next    = mem_col;
    mem_data_next   = mem_data;
    busy_next       = 1'b0;
    done_next       = 1'b0;

    case (state)
      IDLE: begin
        if (clear_start) begin
          // First fill write goes out together with entering CLEAR.
          fill_next     = fill_tile;
          mem_we_next   = 1'b1;
          mem_row_next  = 5'd0;
          mem_col_next  = 5'd0;
          mem_data_next = fill_tile;
          cnt_row_next  = (COL_LAST == 5'd0) ? 5'd1 : 5'd0;
          cnt_col_next  = (COL_LAST == 5'd0) ? 5'd0 : 5'd1;
          last_next     = (ROW_LAST == 5'd0) && (COL_LAST == 5'd0);
          busy_next     = 1'b1;
        end else if (load_start) begin
          cnt_row_next    = 5'd0;
          cnt_col_next    = 5'd0;
          tile_ready_next = 1'b1;
          busy_next       = 1'b1;
        end else if (wr_req) begin
          if (pw_ok) begin
            mem_we_next   = 1'b1;
            mem_row_next  = pw_row;
            mem_col_next  = pw_col;
            mem_data_next = wr_tile;
            wr_ack_next   = 1'b1;
          end else begin
            wr_err_next = 1'b1;
          end
        end
      end

      CLEAR: begin
        if (last_wr) begin
          done_next = 1'b1;
        end else begin
          mem_we_next   = 1'b1;
          mem_row_next  = cnt_row;
          mem_col_next  = cnt_col;
          mem_data_next = fill_q;
          cnt_row_next  = adv_row;
          cnt_col_next  = adv_col;
          last_next     = cnt_at_end;
          busy_next     = 1'b1;
        end
      end

      LOAD: begin
        if (last_wr) begin
          done_next = 1'b1;
        end else begin
          busy_next       = 1'b1;
          tile_ready_next = 1'b1;
          if (accept) begin
            mem_we_next   = 1'b1;
            mem_row_next  = cnt_row;
            mem_col_next  = cnt_col;
            mem_data_next = tile_data;
            cnt_row_next  = adv_row;
            cnt_col_next  = adv_col;
            if (cnt_at_end) begin
              // Stop accepting immediately after the final tile.
              last_next       = 1'b1;
              tile_ready_next = 1'b0;
            end
          end
        end
      end

      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_row    <= 5'd0;
      cnt_col    <= 5'd0;
      fill_q     <= 3'd0;
      last_wr    <= 1'b0;
      tile_ready <= 1'b0;
      wr_ack     <= 1'b0;
      wr_err     <= 1'b0;
      mem_we     <= 1'b0;
      mem_row    <= 5'd0;
      mem_col    <= 5'd0;
      mem_data   <= 3'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      cnt_row    <= cnt_row_next;
      cnt_col    <= cnt_col_next;
      fill_q     <= fill_next;
      last_wr    <= last_next;
      tile_ready <= tile_ready_next;
      wr_ack     <= wr_ack_next;
      wr_err     <= wr_err_next;
      mem_we     <= mem_we_next;
      mem_row    <= mem_row_next;
      mem_col    <= mem_col_next;
      mem_data   <= mem_data_next;
      busy       <= busy_next;
      done       <= done_next;
    end
  end

endmodule

// File: tb/tb_level_writer.sv
// -----------------------------------------------------------------------------
// tb_level_writer
//
// Directed self-checking bench for level_writer. Inputs are driven and outputs
// sampled on the falling clock edge; each scenario task does its own checks.
// -----------------------------------------------------------------------------
module tb_level_writer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear_start, load_start, tile_valid, wr_req;
  logic [2:0] fill_tile, tile_data, wr_tile;
  logic [9:0] wr_x, wr_y;
  logic       tile_ready, wr_ack, wr_err, mem_we, busy, done;
  logic [4:0] mem_row, mem_col;
  logic [2:0] mem_data;

  int n_pass  = 0;
  int n_total = 0;

  wire [18:0] outs = {tile_ready, wr_ack, wr_err, mem_we, mem_row, mem_col,
                      mem_data, busy, done};

  always #5 clk = ~clk;

  level_writer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_start(clear_start),
    .fill_tile  (fill_tile),
    .load_start (load_start),
    .tile_valid (tile_valid),
    .tile_data  (tile_data),
    .tile_ready (tile_ready),
    .wr_req     (wr_req),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_tile    (wr_tile),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .mem_we     (mem_we),
    .mem_row    (mem_row),
    .mem_col    (mem_col),
    .mem_data   (mem_data),
    .busy       (busy),
    .done       (done)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if (outs !== 19'h0) $display("FAIL reset_outputs: got %h expected 0", outs);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if (outs !== 19'h0) $display("FAIL idle_after_reset: got %h expected 0", outs);
    else n_pass++;
  endtask

  task automatic test_clear();
    logic [14:0] got, exp;
    fill_tile   = 3'd3;
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    fill_tile   = 3'd6;  // must not affect the running clear
    for (int k = 0; k < 300; k++) begin
      got = {mem_we, mem_row, mem_col, mem_data, busy, done};
      exp = {1'b1, 5'(k / 20), 5'(k % 20), 3'd3, 1'b1, 1'b0};
      n_total++;
      if (got !== exp) $display("FAIL clear_write_%0d: got %h expected %h", k, got, exp);
      else n_pass++;
      @(negedge clk);
    end
    n_total++;
    if ({mem_we, busy, done} !== 3'b001)
      $display("FAIL clear_done: we/busy/done got %b expected 001", {mem_we, busy, done});
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({mem_we, busy, done} !== 3'b000)
      $display("FAIL clear_after_done: we/busy/done got %b expected 000", {mem_we, busy, done});
    else n_pass++;
  endtask

  task automatic test_load();
    int hs = 0;
    int cyc = 0;
    bit exp_we = 1'b0;
    bit done_due = 1'b0;
    bit fin = 1'b0;
    int idx;
    tile_valid = 1'b0;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    while (!fin && cyc < 2000) begin
      n_total++;
      if (mem_we !== exp_we) $display("FAIL load_we_cyc%0d: got %b expected %b", cyc, mem_we, exp_we);
      else n_pass++;
      if (exp_we) begin
        idx = hs - 1;
        n_total++;
        if ({mem_row, mem_col, mem_data} !== {5'(idx / 20), 5'(idx % 20), 3'(idx % 8)})
          $display("FAIL load_write_%0d: got r%0d c%0d d%0d expected r%0d c%0d d%0d",
                   idx, mem_row, mem_col, mem_data, idx / 20, idx % 20, idx % 8);
        else n_pass++;
      end
      n_total++;
      if ({tile_ready, done, busy} !== {hs < 300, done_due, !done_due})
        $display("FAIL load_ctrl_cyc%0d: ready/done/busy got %b expected %b", cyc,
                 {tile_ready, done, busy}, {hs < 300, done_due, !done_due});
      else n_pass++;
      if (done_due) begin
        fin = 1'b1;
      end else begin
        done_due   = exp_we && (hs == 300);
        tile_valid = (cyc % 2 == 0);
        tile_data  = 3'(hs % 8);
        exp_we     = tile_valid && (hs < 300);
        if (exp_we) hs++;
        @(negedge clk);
        cyc++;
      end
    end
    n_total++;
    if (!fin) $display("FAIL load_timeout: got no done, expected done within 2000 cycles");
    else n_pass++;
    @(negedge clk);  // extra valid data must not be accepted
    tile_valid = 1'b0;
    n_total++;
    if ({mem_we, tile_ready, busy, done} !== 4'b0000)
      $display("FAIL load_after_done: we/ready/busy/done got %b expected 0000",
               {mem_we, tile_ready, busy, done});
    else n_pass++;
  endtask

  task automatic point_write(input logic [9:0] x, input logic [9:0] y,
                             input logic [2:0] t, input bit ok,
                             input logic [4:0] r, input logic [4:0] c,
                             input string name);
    wr_x = x; wr_y = y; wr_tile = t; wr_req = 1'b1;
    @(negedge clk);
    n_total++;
    if ({mem_we, wr_ack, wr_err} !== {ok, ok, !ok})
      $display("FAIL %s_pulse: we/ack/err got %b expected %b", name,
               {mem_we, wr_ack, wr_err}, {ok, ok, !ok});
    else n_pass++;
    if (ok) begin
      n_total++;
      if ({mem_row, mem_col, mem_data} !== {r, c, t})
        $display("FAIL %s_addr: got r%0d c%0d d%0d expected r%0d c%0d d%0d", name,
                 mem_row, mem_col, mem_data, r, c, t);
      else n_pass++;
    end
    wr_req = 1'b0;
    @(negedge clk);
    n_total++;
    if ({mem_we, wr_ack, wr_err} !== 3'b000)
      $display("FAIL %s_single: we/ack/err got %b expected 000", name, {mem_we, wr_ack, wr_err});
    else n_pass++;
  endtask

  task automatic test_point_write();
    point_write(10'd176, 10'd67,  3'd5, 1'b1, 5'd1, 5'd1, "pw_valid");
    point_write(10'd143, 10'd100, 3'd2, 1'b0, 5'd0, 5'd0, "pw_left");
    point_write(10'd784, 10'd40,  3'd2, 1'b0, 5'd0, 5'd0, "pw_right");
    point_write(10'd771, 10'd514, 3'd7, 1'b1, 5'd14, 5'd19, "pw_corner");
  endtask

  task automatic test_priority();
    int nwr = 0;
    int cyc = 0;
    bit fin = 1'b0;
    fill_tile = 3'd1; clear_start = 1'b1; load_start = 1'b1;
    wr_x = 10'd272; wr_y = 10'd67; wr_tile = 3'd2; wr_req = 1'b1;
    @(negedge clk);
    clear_start = 1'b0; load_start = 1'b0;
    while (!fin && cyc < 400) begin
      if (mem_we && mem_data == 3'd1) nwr++;
      n_total++;
      if ({wr_ack, tile_ready} !== 2'b00)
        $display("FAIL prio_no_ack_cyc%0d: ack/ready got %b expected 00", cyc, {wr_ack, tile_ready});
      else n_pass++;
      if (done) fin = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    n_total++;
    if (!fin || nwr != 300)
      $display("FAIL prio_clear: got done=%0d writes=%0d expected done=1 writes=300", fin, nwr);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({wr_ack, mem_we, mem_row, mem_col, mem_data} !== {1'b1, 1'b1, 5'd1, 5'd4, 3'd2})
      $display("FAIL prio_held_wr: got ack%b we%b r%0d c%0d d%0d expected ack1 we1 r1 c4 d2",
               wr_ack, mem_we, mem_row, mem_col, mem_data);
    else n_pass++;
    wr_req = 1'b0;
    @(negedge clk);
    n_total++;
    if ({wr_ack, tile_ready, busy, mem_we} !== 4'b0000)
      $display("FAIL prio_load_dropped: ack/ready/busy/we got %b expected 0000",
               {wr_ack, tile_ready, busy, mem_we});
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    tile_valid = 1'b1;
    for (int i = 0; i < 150; i++) begin
      tile_data = 3'(i % 8);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (outs !== 19'h0) $display("FAIL abort_async: got %h expected 0", outs);
    else n_pass++;
    tile_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      n_total++;
      if (outs !== 19'h0) $display("FAIL abort_held: got %h expected 0", outs);
      else n_pass++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_total++;
      if ({done, busy, mem_we} !== 3'b000)
        $display("FAIL abort_no_done: done/busy/we got %b expected 000", {done, busy, mem_we});
      else n_pass++;
    end
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    n_total++;
    if (tile_ready !== 1'b1) $display("FAIL reload_ready: got %b expected 1", tile_ready);
    else n_pass++;
    tile_valid = 1'b1;
    tile_data  = 3'd5;
    @(negedge clk);
    tile_valid = 1'b0;
    n_total++;
    if ({mem_we, mem_row, mem_col, mem_data} !== {1'b1, 5'd0, 5'd0, 3'd5})
      $display("FAIL reload_first: got we%b r%0d c%0d d%0d expected we1 r0 c0 d5",
               mem_we, mem_row, mem_col, mem_data);
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_start = 1'b0; load_start = 1'b0; tile_valid = 1'b0; wr_req = 1'b0;
    fill_tile = 3'd0; tile_data = 3'd0; wr_tile = 3'd0; wr_x = 10'd0; wr_y = 10'd0;
    test_reset();
    test_clear();
    test_load();
    test_point_write();
    test_priority();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 500000");
    $fatal(1, "simulation timeout");
  end

endmodule
